// File: rtl/dp_arb_pkg.sv
// Shared definitions for the datapath arbiter: FSM state encoding and an index helper.
package dp_arb_pkg;

    localparam int unsigned StateWidth = 2;

    typedef enum logic [StateWidth-1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StBusy   = 2'd2,
        StRetire = 2'd3
    } state_e;

    // Supports up to 8 requesters; callers zero-extend and truncate as needed.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after the last served index,
// wrapping back to index 0.
module rr_picker
    import dp_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last_served,
    output logic [$clog2(NREQ)-1:0] o_pick_idx,
    output logic                    o_pick_valid
);

    localparam int unsigned IdxW = $clog2(NREQ);

    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_masked;
    logic [NREQ-1:0] w_sel;
    logic [NREQ-1:0] w_pick_oh;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mask[i] = (i > int'(i_last_served));
        end
    end

    // Requests above last_served take priority; otherwise wrap to the full vector.
    assign w_masked     = i_req & w_mask;
    assign w_sel        = (|w_masked) ? w_masked : i_req;
    assign w_pick_oh    = w_sel & (~w_sel + NREQ'(1));
    assign o_pick_valid = |i_req;
    assign o_pick_idx   = IdxW'(onehot_to_idx(8'(w_pick_oh)));

endmodule

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter sharing one start/done compute unit between NREQ requesters,
// with an optional BUSY watchdog.
module datapath_arbiter
    import dp_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req,
    input  logic                    i_unit_done,
    output logic                    o_unit_start,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_grant_idx,
    output logic [NREQ-1:0]         o_ack,
    output logic                    o_busy,
    output logic                    o_timeout_err
);

    localparam int unsigned     IdxW    = $clog2(NREQ);
    localparam int unsigned     CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    state_e          r_state,       w_state_nxt;
    logic [IdxW-1:0] r_owner,       w_owner_nxt;
    logic [IdxW-1:0] r_last,        w_last_nxt;
    logic [CntW-1:0] r_cnt,         w_cnt_nxt;
    logic            r_timed_out,   w_timed_out_nxt;
    logic            r_timeout_err, w_timeout_err_nxt;

    logic [IdxW-1:0] w_pick_idx;
    logic            w_pick_valid;

    rr_picker #(
        .NREQ(NREQ)
    ) u_rr_picker (
        .i_req        (i_req),
        .i_last_served(r_last),
        .o_pick_idx   (w_pick_idx),
        .o_pick_valid (w_pick_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_owner       <= '0;
            r_last        <= IdxW'(NREQ - 1);
            r_cnt         <= '0;
            r_timed_out   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last        <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timed_out   <= w_timed_out_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_last_nxt        = r_last;
        w_cnt_nxt         = r_cnt;
        w_timed_out_nxt   = r_timed_out;
        w_timeout_err_nxt = r_timeout_err;
        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_owner_nxt = w_pick_idx;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StBusy;
            end
            StBusy: begin
                if (r_cnt != CntMax) w_cnt_nxt = r_cnt + CntW'(1);
                // Completion beats a watchdog expiry landing in the same cycle.
                if (i_unit_done) begin
                    w_timed_out_nxt = 1'b0;
                    w_state_nxt     = StRetire;
                end else if ((TIMEOUT != 0) && (r_cnt == CntLast)) begin
                    w_timed_out_nxt   = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = StRetire;
                end
            end
            StRetire: begin
                w_last_nxt  = r_owner;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_ack       = '0;
        if (r_state != StIdle) begin
            o_grant[r_owner] = 1'b1;
            o_grant_idx      = r_owner;
        end
        if ((r_state == StRetire) && !r_timed_out) o_ack[r_owner] = 1'b1;
    end

    assign o_unit_start  = (r_state == StIssue);
    assign o_busy        = (r_state != StIdle);
    assign o_timeout_err = r_timeout_err;

endmodule
